rom_region_loader: RTL
======================

Name: rom_region_loader

Overview:
- Consumes the MiSTer ioctl ROM download byte stream and dispatches each byte to one of NUM_REGIONS load regions.
- A region with a nonzero chip-select mask targets BRAM: byte writes with a one-hot chip select.
- A region with a zero mask targets SDRAM: 16-bit word writes at base_addr + offset, with a req/ack handshake.
- Region lengths come from 32-bit headers in the stream, so the MRA decides sizes and no per-game RTL is needed. Sits between hps_io and the SDRAM controller / ROM BRAMs.

Parameters:
- NUM_REGIONS, 9, number of load regions, processed in index order.
- CS_W, 6, width of the BRAM chip-select mask.
- SDR_AW, 25, SDRAM byte-address width.
- BRAM_AW, 16, BRAM byte-address width.
- REGION_BASE, all zero, packed NUM_REGIONS*SDR_AW; region i base is at slice [i*SDR_AW +: SDR_AW].
- REGION_CS, all zero, packed NUM_REGIONS*CS_W; region i mask; 0 = SDRAM region.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  high for the whole ROM download.
- ioctl_wr  in  1  one-cycle strobe; the byte in ioctl_data is valid.
- ioctl_data  in  8  download byte.
- ioctl_wait  out  1  backpressure to hps_io.
- bram_wr  out  1  one-cycle BRAM write strobe.
- bram_cs  out  CS_W  region chip-select mask, qualified by bram_wr.
- bram_addr  out  BRAM_AW  byte offset within the region.
- bram_data  out  8  write byte.
- sdr_req  out  1  SDRAM write request, held until ack.
- sdr_ack  in  1  one-cycle acknowledge from the SDRAM controller.
- sdr_addr  out  SDR_AW  word-aligned byte address; bit0 is always 0.
- sdr_data  out  16  write data; even-offset byte in [7:0], odd-offset byte in [15:8].
- sdr_be  out  2  byte enables.
- load_done  out  1  download finished.
- load_error  out  1  malformed stream.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; region index 0.
- Stream format, per region in index order: 4-byte big-endian length L, then L data bytes. L = 0 means no data; move to the next header.
- States: IDLE, HDR, DATA, SDR_WAIT, DONE.
- IDLE: a rising edge of ioctl_download clears load_done, load_error, the region index and the header byte count, then enters HDR.
- HDR: each ioctl_wr shifts one byte into the length register. After the 4th byte:
  - L = 0: index++, stay in HDR.
  - L > 0: clear the offset counter and enter DATA.
  - When the index reaches NUM_REGIONS, enter DONE_PENDING, which is encoded as HDR with the index equal to NUM_REGIONS.
- HDR with index == NUM_REGIONS: any further ioctl_wr sets load_error; the byte is discarded.
- DATA with a BRAM region (mask != 0): each ioctl_wr produces, on the next cycle, bram_wr = 1 with bram_addr = offset[BRAM_AW-1:0], bram_data = byte and bram_cs = mask.
  - Latency 1 cycle; accepts a byte every cycle; no backpressure.
  - Offsets at or above 2^BRAM_AW wrap silently.
- DATA with an SDRAM region (mask == 0): an even-offset byte is latched into the low half. On an odd-offset byte, or the region's last byte:
  - sdr_addr = base + {offset[SDR_AW-1:1], 0}.
  - sdr_be = 11; or 01 if the last byte is at an even offset.
  - sdr_req = 1 next cycle; enter SDR_WAIT.
- SDR_WAIT: ioctl_wait = 1. sdr_req and the sdr_* outputs are held stable until sdr_ack. On sdr_ack, sdr_req drops in the same edge; return to DATA or move to the next header.
  - An ioctl_wr during SDR_WAIT is a protocol violation: set load_error; the byte is dropped.
- Offset increments per accepted data byte. When offset == L-1 is consumed: index++, header count cleared, return to HDR (after SDR_WAIT when applicable).
- Address arithmetic: base + offset is modulo 2^SDR_AW; no overflow detection.
- ioctl_download falling edge, in any state:
  - If an SDRAM request is outstanding, finish it first.
  - Then enter DONE: load_done = 1.
  - load_error is set if the index is not NUM_REGIONS, i.e. a short stream.
- DONE: outputs hold until the next rising edge of ioctl_download.
- reset mid-download: immediate return to reset values, with sdr_req dropped asynchronously. The SDRAM controller must tolerate an abandoned request.
- ioctl_wr and a download edge in the same cycle: the edge takes priority and the byte is ignored.

Test Plan:
- 2 regions, both BRAM (CS 000001 and 000010); stream 00000002 AA BB 00000001 CC; then download falls.
  - Required: bram_wr pulses at (cs 01, addr 0, AA), (cs 01, addr 1, BB), (cs 10, addr 0, CC), each 1 cycle after its ioctl_wr.
  - Required: load_done = 1, load_error = 0.
- SDRAM region, base 0x040000, L = 3, bytes 11 22 33; ack delayed by 5 cycles.
  - Required: first write has addr 0x040000, data 0x2211, be 11; second has addr 0x040002, data 0x0033 low byte, be 01.
  - Required: ioctl_wait is high exactly while sdr_req is high.
- Zero-length region in the middle: headers 1, 0, 1 with bytes 5A and A5 -> the second data byte is written to region 2; region 1 gets no writes.
- Short stream: 9 regions configured, download falls after 3 complete -> load_done = 1, load_error = 1.
- Extra byte after all regions are loaded -> load_error = 1, no write strobe.
- Reset asserted during SDR_WAIT -> sdr_req = 0 and ioctl_wait = 0 immediately.
  - Then a fresh download with 1 region (L = 2) completes with load_error = 0.

Source files
------------

// File: rtl/rom_region_loader.sv
// Routes the ioctl ROM download stream into BRAM or SDRAM load regions.
// Each region is preceded by a 32-bit big-endian length header.
module rom_region_loader #(
    parameter int NUM_REGIONS = 9,
    parameter int CS_W        = 6,
    parameter int SDR_AW      = 25,
    parameter int BRAM_AW     = 16,
    parameter logic [NUM_REGIONS*SDR_AW-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*CS_W-1:0]   REGION_CS   = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [7:0]         ioctl_data,
    output logic               ioctl_wait,
    output logic               bram_wr,
    output logic [CS_W-1:0]    bram_cs,
    output logic [BRAM_AW-1:0] bram_addr,
    output logic [7:0]         bram_data,
    output logic               sdr_req,
    input  logic               sdr_ack,
    output logic [SDR_AW-1:0]  sdr_addr,
    output logic [15:0]        sdr_data,
    output logic [1:0]         sdr_be,
    output logic               load_done,
    output logic               load_error
);

    localparam int IW = $clog2(NUM_REGIONS + 1);
    localparam logic [IW-1:0] IDX_END = IW'(NUM_REGIONS);

    typedef enum logic [2:0] {IDLE, HDR, DATA, SDR_WAIT, DONE} state_t;

    state_t             state_q;
    logic               dl_q;
    logic [IW-1:0]      idx_q;
    logic [1:0]         hcnt_q;
    logic [31:0]        len_q;
    logic [31:0]        off_q;
    logic [7:0]         lo_q;
    logic               ret_hdr_q;
    logic               done_pend_q;
    logic               bram_wr_q;
    logic [CS_W-1:0]    bram_cs_q;
    logic [BRAM_AW-1:0] bram_addr_q;
    logic [7:0]         bram_data_q;
    logic               sdr_req_q;
    logic [SDR_AW-1:0]  sdr_addr_q;
    logic [15:0]        sdr_data_q;
    logic [1:0]         sdr_be_q;
    logic               done_q;
    logic               err_q;

    logic               rise;
    logic               fall;
    logic               wr;
    logic               last;
    logic               short_err;
    logic [IW-1:0]      sel_idx;
    logic [CS_W-1:0]    cur_cs;
    logic [SDR_AW-1:0]  cur_base;
    logic [SDR_AW-1:0]  word_addr;
    logic [31:0]        len_nxt;

    // Download edges win over a coincident byte strobe
    assign rise      = ioctl_download & ~dl_q;
    assign fall      = ~ioctl_download & dl_q;
    assign wr        = ioctl_wr & ~rise & ~fall;
    assign last      = (off_q == len_q - 32'd1);
    assign short_err = (idx_q != IDX_END);
    assign sel_idx   = (idx_q < IDX_END) ? idx_q : '0;
    assign cur_cs    = REGION_CS[int'(sel_idx)*CS_W +: CS_W];
    assign cur_base  = REGION_BASE[int'(sel_idx)*SDR_AW +: SDR_AW];
    assign word_addr = cur_base + {off_q[SDR_AW-1:1], 1'b0};
    assign len_nxt   = {len_q[23:0], ioctl_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dl_q        <= 1'b0;
            idx_q       <= '0;
            hcnt_q      <= '0;
            len_q       <= '0;
            off_q       <= '0;
            lo_q        <= '0;
            ret_hdr_q   <= 1'b0;
            done_pend_q <= 1'b0;
            bram_wr_q   <= 1'b0;
            bram_cs_q   <= '0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
            sdr_req_q   <= 1'b0;
            sdr_addr_q  <= '0;
            sdr_data_q  <= '0;
            sdr_be_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            dl_q      <= ioctl_download;
            bram_wr_q <= 1'b0;
            if (rise && state_q != SDR_WAIT) begin
                state_q     <= HDR;
                done_q      <= 1'b0;
                err_q       <= 1'b0;
                idx_q       <= '0;
                hcnt_q      <= '0;
                done_pend_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE, DONE: begin
                        if (fall) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            if (short_err) err_q <= 1'b1;
                        end
                    end
                    HDR: begin
                        if (fall) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            if (short_err) err_q <= 1'b1;
                        end else if (wr) begin
                            if (idx_q == IDX_END) begin
                                err_q <= 1'b1;
                            end else begin
                                len_q  <= len_nxt;
                                hcnt_q <= hcnt_q + 2'd1;
                                if (hcnt_q == 2'd3) begin
                                    if (len_nxt == 32'd0) begin
                                        idx_q <= idx_q + 1'b1;
                                    end else begin
                                        off_q   <= '0;
                                        state_q <= DATA;
                                    end
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (fall) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            if (short_err) err_q <= 1'b1;
                        end else if (wr) begin
                            off_q <= off_q + 32'd1;
                            if (last) begin
                                idx_q  <= idx_q + 1'b1;
                                hcnt_q <= '0;
                            end
                            if (cur_cs != '0) begin
                                bram_wr_q   <= 1'b1;
                                bram_cs_q   <= cur_cs;
                                bram_addr_q <= off_q[BRAM_AW-1:0];
                                bram_data_q <= ioctl_data;
                                if (last) state_q <= HDR;
                            end else begin
                                if (!off_q[0]) lo_q <= ioctl_data;
                                if (off_q[0] || last) begin
                                    sdr_req_q  <= 1'b1;
                                    sdr_addr_q <= word_addr;
                                    sdr_data_q <= off_q[0] ? {ioctl_data, lo_q}
                                                           : {8'h00, ioctl_data};
                                    sdr_be_q   <= off_q[0] ? 2'b11 : 2'b01;
                                    ret_hdr_q  <= last;
                                    state_q    <= SDR_WAIT;
                                end
                            end
                        end
                    end
                    SDR_WAIT: begin
                        if (wr) err_q <= 1'b1;
                        if (fall) done_pend_q <= 1'b1;
                        if (sdr_ack) begin
                            sdr_req_q <= 1'b0;
                            if (done_pend_q || fall) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                if (short_err) err_q <= 1'b1;
                            end else begin
                                state_q <= ret_hdr_q ? HDR : DATA;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ioctl_wait = sdr_req_q;
    assign bram_wr    = bram_wr_q;
    assign bram_cs    = bram_cs_q;
    assign bram_addr  = bram_addr_q;
    assign bram_data  = bram_data_q;
    assign sdr_req    = sdr_req_q;
    assign sdr_addr   = sdr_addr_q;
    assign sdr_data   = sdr_data_q;
    assign sdr_be     = sdr_be_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule
